merge_arbiter: RTL and testbench
================================

MERGE_ARBITER -- requirements
Module: merge_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive grants to one input while the other is waiting; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the grant statistics counters.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid  in  1  requester 0 has a packet pending at merge input L0.
REQ-007 req0_ready  out  1  grant-consumed acknowledge to requester 0.
REQ-008 req1_valid  in  1  requester 1 has a packet pending at merge input L1.
REQ-009 req1_ready  out  1  grant-consumed acknowledge to requester 1.
REQ-010 sel  out  1  select token for the merge: 0 = L0, 1 = L1.
REQ-011 sel_valid  out  1  select token offered.
REQ-012 sel_ready  in  1  merge accepts the select token.
REQ-013 busy  out  1  high while state is OFFER.
REQ-014 grant_cnt0, grant_cnt1  out  CNT_W  grants completed per input (present only when MERGE_ARB_STATS_EN is defined).

Function
REQ-015 FSM states SHALL be IDLE and OFFER only.
REQ-016 IDLE: if req0_valid or req1_valid is high at a rising edge, the block SHALL register the winner into sel, set sel_valid=1 and enter OFFER; otherwise it SHALL stay in IDLE.
REQ-017 OFFER: sel and sel_valid SHALL hold stable until a cycle with sel_valid && sel_ready; at that edge the FSM SHALL return to IDLE and sel_valid SHALL drop.
REQ-018 reqX_ready SHALL be combinational: sel_valid && sel_ready && (sel==X); it pulses for exactly the handshake cycle.
REQ-019 Requesters SHALL hold reqX_valid until reqX_ready; a valid deasserted during OFFER SHALL NOT cancel the offered token.
REQ-020 Latency: sel_valid SHALL rise one cycle after valid is sampled in IDLE; maximum throughput SHALL be one grant per 2 cycles.
REQ-021 Arbitration state SHALL consist of last (1 bit) and burst_cnt (4 bits, saturating at MAX_BURST).
REQ-022 Only one valid: that input SHALL win.
REQ-023 Both valid: last SHALL win if burst_cnt < MAX_BURST, otherwise the other input SHALL win.
REQ-024 At the decision edge: a winner equal to last SHALL increment burst_cnt, saturating at MAX_BURST; a different winner SHALL set last=winner and burst_cnt=1.
REQ-025 MAX_BURST=1 SHALL produce strict alternation under continuous dual requests.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, sel=0, sel_valid=0, busy=0, last=0, burst_cnt=0, and grant counters to 0, asynchronously.
REQ-027 Reset asserted in OFFER SHALL drop sel_valid immediately; no reqX_ready pulse SHALL occur, and the token SHALL be lost.
REQ-028 After rst_n rises, the first decision SHALL occur at the first rising edge with a valid high.

Configuration
REQ-029 Macro MERGE_ARB_STATS_EN defined: grant_cnt0 and grant_cnt1 SHALL exist, each incrementing by 1 on its input's handshake and wrapping modulo 2^CNT_W.
REQ-030 Macro MERGE_ARB_STATS_EN undefined: the counter ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 MAX_BURST=4, both valid continuously, sel_ready=1 -> sel sequence 0,0,0,0,1,1,1,1,0, one token every 2 cycles.
REQ-032 MAX_BURST=1, both valid continuously -> sel sequence 0,1,0,1; each reqX_ready pulses once per own token.
REQ-033 Only req1_valid for 6 grants, then req0_valid also raised (MAX_BURST=4) -> next token is sel=0.
REQ-034 sel_ready held 0 for 5 cycles in OFFER -> sel and sel_valid stable, both ready outputs 0; sel_ready=1 -> single ready pulse, then IDLE.
REQ-035 rst_n pulsed low mid-OFFER -> sel_valid=0 within the same cycle, no ready pulse; after release, the first tie goes to input 0.
REQ-036 MERGE_ARB_STATS_EN with CNT_W=4, 17 grants to input 0 -> grant_cnt0=1 and grant_cnt1=0.

Source files
------------

// File: rtl/merge_arbiter.sv
// merge_arbiter: two-input arbiter issuing a select token to a downstream merge.
// Arbitration favours the input granted last until it has received MAX_BURST
// consecutive grants while the other input waits, then hands over.
// Optional build macro MERGE_ARB_STATS_EN adds per-input grant counters
// (grant_cnt0 / grant_cnt1); without it those ports and registers are absent.
module merge_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_valid,
    output logic req0_ready,
    input  logic req1_valid,
    output logic req1_ready,
    output logic sel,
    output logic sel_valid,
    input  logic sel_ready,
    output logic busy
`ifdef MERGE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    // Reject out-of-range configurations at elaboration time.
    generate
        if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
            $error("merge_arbiter: MAX_BURST must be within 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("merge_arbiter: CNT_W must be at least 1");
        end
    endgenerate

    state_t     state;
    logic       last;
    logic [3:0] burst_cnt;
    logic       any_req;
    logic       winner;
    logic       handshake;

    // Burst counter increment that sticks at MAX_BURST.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        if (cnt >= MAX_B) begin
            return MAX_B;
        end
        return cnt + 4'd1;
    endfunction

    // A lone requester always wins; on a tie the last winner keeps the grant
    // until its burst is exhausted.
    function automatic logic pick_winner(input logic v0, input logic v1,
                                         input logic lst, input logic [3:0] cnt);
        if (v0 && !v1) begin
            return 1'b0;
        end
        if (v1 && !v0) begin
            return 1'b1;
        end
        return (cnt < MAX_B) ? lst : ~lst;
    endfunction

    // Decision inputs and the combinational grant-consumed acknowledges.
    always_comb begin
        any_req    = req0_valid | req1_valid;
        winner     = pick_winner(req0_valid, req1_valid, last, burst_cnt);
        handshake  = sel_valid & sel_ready;
        req0_ready = handshake & ~sel;
        req1_ready = handshake & sel;
    end

    // IDLE/OFFER controller with registered token outputs and burst tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b0;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel       <= winner;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= OFFER;
                        if (winner == last) begin
                            burst_cnt <= sat_inc(burst_cnt);
                        end else begin
                            last      <= winner;
                            burst_cnt <= 4'd1;
                        end
                    end
                end
                OFFER: begin
                    // Token stays put until the merge takes it.
                    if (sel_ready) begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MERGE_ARB_STATS_EN
    // Completed-grant counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (req1_ready) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_merge_arbiter.sv
// tb_merge_arbiter: randomized and directed bench for merge_arbiter.
// The reference model keeps the list of past winners and derives each
// decision from the trailing run length in that list.
module tb_merge_arbiter;

    logic clk;
    logic rst_n;
    logic req0_valid;
    logic req1_valid;
    logic sel_ready;
    logic req0_ready, req1_ready, sel, sel_valid, busy;
    logic req0_ready_b, req1_ready_b, sel_b, sel_valid_b, busy_b;
`ifdef MERGE_ARB_STATS_EN
    logic [3:0]  grant_cnt0, grant_cnt1;
    logic [15:0] grant_cnt0_b, grant_cnt1_b;
`endif

    merge_arbiter #(.MAX_BURST(4), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .sel(sel), .sel_valid(sel_valid), .sel_ready(sel_ready), .busy(busy)
`ifdef MERGE_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    // Second instance shares all inputs; used for the strict-alternation case.
    merge_arbiter #(.MAX_BURST(1), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready_b),
        .sel(sel_b), .sel_valid(sel_valid_b), .sel_ready(sel_ready), .busy(busy_b)
`ifdef MERGE_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0_b), .grant_cnt1(grant_cnt1_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int hist[$];
    bit m_offer;
    int m_sel;
    int m_cnt0, m_cnt1;
    bit hs0, hs1;
    int dut_tokens[$];
    int alt_tokens[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner from the arbitration rules: lone requester wins; on a tie the
    // previous winner keeps it while its trailing run is shorter than mb.
    function automatic int model_pick(input bit v0, input bit v1, input int mb);
        int lst;
        int streak;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        lst = 0;
        streak = 0;
        if (hist.size() > 0) begin
            lst = hist[hist.size()-1];
            for (int i = hist.size() - 1; i >= 0 && hist[i] == lst; i--) streak++;
        end
        return (streak < mb) ? lst : 1 - lst;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_offer = 0;
        m_sel = 0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        hs0 = 0;
        hs1 = 0;
        dut_tokens.delete();
        alt_tokens.delete();
    endtask

    // Called just after a falling edge: drive inputs, check, advance one clock.
    task automatic cycle(input bit v0, input bit v1, input bit rdy);
        req0_valid = v0;
        req1_valid = v1;
        sel_ready  = rdy;
        #1;
        check("sel_valid", sel_valid, m_offer);
        check("busy", busy, m_offer);
        if (m_offer) check("sel", sel, m_sel);
        check("req0_ready", req0_ready, m_offer && rdy && m_sel == 0);
        check("req1_ready", req1_ready, m_offer && rdy && m_sel == 1);
`ifdef MERGE_ARB_STATS_EN
        check("grant_cnt0", grant_cnt0, m_cnt0 & 15);
        check("grant_cnt1", grant_cnt1, m_cnt1 & 15);
`endif
        if (req0_ready || req1_ready) dut_tokens.push_back(int'(sel));
        if (req0_ready_b || req1_ready_b) alt_tokens.push_back(int'(req1_ready_b));
        @(posedge clk);
        hs0 = 0;
        hs1 = 0;
        if (m_offer) begin
            if (rdy) begin
                m_offer = 0;
                if (m_sel == 0) begin m_cnt0++; hs0 = 1; end
                else begin m_cnt1++; hs1 = 1; end
            end
        end else if (v0 || v1) begin
            m_sel = model_pick(v0, v1, 4);
            hist.push_back(m_sel);
            m_offer = 1;
        end
        @(negedge clk);
    endtask

    // Assert reset between edges, check the asynchronous clear, release on a falling edge.
    task automatic do_reset();
        sel_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_sel_valid", sel_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        sel_ready = 1'b1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
`ifdef MERGE_ARB_STATS_EN
        check("rst_cnt0", grant_cnt0, 0);
        check("rst_cnt1", grant_cnt1, 0);
`endif
        sel_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    bit pend0, pend1, rdy_r;

    initial begin
        int exp_seq[9];
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sel_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Continuous dual requests, sel_ready always high.
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int n = 0; n < 18; n++) cycle(1, 1, 1);
        check("burst4_tokens", dut_tokens.size(), 9);
        check("alt_tokens", alt_tokens.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < dut_tokens.size()) check("burst4_seq", dut_tokens[i], exp_seq[i]);
            if (i < alt_tokens.size()) check("alt_seq", alt_tokens[i], i % 2);
        end

        // Input 1 alone for six grants, then both: input 0 must take over.
        do_reset();
        for (int n = 0; n < 12; n++) cycle(0, 1, 1);
        for (int n = 0; n < 2; n++) cycle(1, 1, 1);
        check("handover_tokens", dut_tokens.size(), 7);
        if (dut_tokens.size() == 7) check("handover_sel", dut_tokens[6], 0);

        // Stalled merge, then a valid dropped during OFFER must not cancel.
        do_reset();
        cycle(1, 0, 0);
        for (int n = 0; n < 5; n++) cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        check("stall_pulses", dut_tokens.size(), 1);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        check("dropped_valid_tokens", dut_tokens.size(), 2);

        // Reset in the middle of an offer, then the first tie goes to input 0.
        do_reset();
        cycle(0, 1, 0);
        check("pre_reset_offer", sel_valid, 1);
        do_reset();
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        check("post_reset_tokens", dut_tokens.size(), 1);
        if (dut_tokens.size() == 1) check("post_reset_sel", dut_tokens[0], 0);

`ifdef MERGE_ARB_STATS_EN
        // Counter wrap: 17 grants to input 0 with a 4-bit counter.
        do_reset();
        for (int n = 0; n < 17; n++) begin
            cycle(1, 0, 1);
            cycle(1, 0, 1);
        end
        cycle(0, 0, 0);
        check("wrap_cnt0", grant_cnt0, 1);
        check("wrap_cnt1", grant_cnt1, 0);
`endif

        // Randomized requesters that hold valid until their grant is consumed.
        do_reset();
        pend0 = 0;
        pend1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) pend0 = 1;
            if (!pend1 && $urandom_range(0, 2) != 0) pend1 = 1;
            rdy_r = ($urandom_range(0, 3) != 0);
            cycle(pend0, pend1, rdy_r);
            if (hs0) pend0 = 0;
            if (hs1) pend1 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
